xtea_drv: RTL and testbench
===========================

XTEA_DRV -- requirements
Module: xtea_drv

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning input command FIFO depth (power of 2, ≥2).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for core_valid_i after an issue.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 s_valid_i  input  1  upstream block valid.
REQ-006 s_ready_o  output  1  upstream may push.
REQ-007 s_data_i  input  64  plaintext or ciphertext block.
REQ-008 s_key_i  input  128  key, captured with the block.
REQ-009 s_decrypt_i  input  1  per-block direction, 1=decrypt.
REQ-010 core_valid_o, core_en_o  output  1 each  request pulse to XTEA core.
REQ-011 core_data_o  output  64, core_key_o  output  128, core_decrypt_o  output  1  request payload to core.
REQ-012 core_result_i  input  64, core_valid_i  input  1, core_busy_i  input  1  core response.
REQ-013 m_valid_o  output  1, m_ready_i  input  1, m_data_o  output  64, m_decrypt_o  output  1  downstream result.
REQ-014 err_o  output  1  sticky timeout flag.
REQ-015 blk_cnt_o  output  16  count of completed blocks.

Function
REQ-016 Push SHALL occur when s_valid_i && s_ready_o; s_ready_o = FIFO not full, with no same-cycle bypass of a pop.
REQ-017 FIFO entries SHALL hold {data, key, decrypt} (193 bits); pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-019 IDLE -> ISSUE when FIFO non-empty && !core_busy_i; head entry SHALL be popped and registered onto the core_* payload on that edge.
REQ-020 In ISSUE, core_valid_o and core_en_o SHALL be high for exactly one cycle; ISSUE -> WAIT unconditionally.
REQ-021 core_data_o, core_key_o and core_decrypt_o SHALL hold their value from issue until the next issue.
REQ-022 In WAIT, the first cycle with core_valid_i=1 SHALL capture core_result_i into m_data_o and the issued direction into m_decrypt_o, then transition WAIT -> HOLD.
REQ-023 A WAIT cycle counter SHALL start at 0; if it reaches TIMEOUT without core_valid_i, err_o SHALL be set, the block dropped, and the FSM SHALL go WAIT -> IDLE.
REQ-024 core_valid_i seen in IDLE, ISSUE or HOLD SHALL be ignored.
REQ-025 In HOLD, m_valid_o=1 with m_data_o and m_decrypt_o stable until m_ready_i=1; then HOLD -> IDLE and blk_cnt_o SHALL increment by 1, wrapping 0xFFFF -> 0.
REQ-026 Minimum push-to-issue latency SHALL be 2 cycles; one block SHALL be in flight at a time.
REQ-027 Pushes SHALL be accepted in any state, including a push on the same cycle as a pop (count unchanged).
REQ-028 err_o SHALL clear only on reset.

Reset
REQ-029 When rst_i=0, asynchronously: FSM=IDLE, FIFO empty, s_ready_o=1, core_valid_o=0, core_en_o=0, core_data_o=0, core_key_o=0, core_decrypt_o=0, m_valid_o=0, m_data_o=0, m_decrypt_o=0, err_o=0, blk_cnt_o=0, timeout counter=0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight and queued blocks; a core response arriving after reset release SHALL be ignored per REQ-024.

Verification
REQ-031 Push 0x0000000000000000 with key 0x000102030405060708090A0B0C0D0E0F, encrypt; core model responds 32 cycles later -> single 1-cycle core_valid_o/core_en_o; m_data_o = model result; blk_cnt_o=1.
REQ-032 Push 6 blocks back-to-back with FIFO_DEPTH=4 while core_busy_i=1 -> s_ready_o low after 4th accept; release busy -> all 6 complete in order.
REQ-033 Encrypt result pushed back with s_decrypt_i=1 and same key -> m_data_o equals original plaintext; m_decrypt_o=1.
REQ-034 Core never responds -> err_o=1 exactly TIMEOUT cycles into WAIT, FSM back to IDLE, next block processes normally, err_o stays 1.
REQ-035 Hold m_ready_i=0 for 10 cycles in HOLD -> m_data_o stable, no new core_valid_o; m_ready_i=1 -> blk_cnt_o increments once.
REQ-036 Assert rst_i=0 during WAIT with 3 blocks queued -> all outputs at reset values immediately; late core_valid_i produces no m_valid_o.

Source files
------------

// File: rtl/xtea_drv.sv
// ----------------------------------------------------------------------------
// xtea_drv
//   Command driver for a single-block XTEA core. Upstream blocks
//   {data, key, direction} are queued in a small FIFO. They are then issued
//   one at a time to the core as a one-cycle request pulse. The core's answer
//   is held on a valid/ready downstream port until it is consumed. If the
//   core does not answer within TIMEOUT cycles, the block is dropped and the
//   sticky err_o flag is raised.
//
// Parameters
//   FIFO_DEPTH : command FIFO depth (power of two, >= 2)
//   TIMEOUT    : WAIT cycles allowed for core_valid_i before dropping (>= 1)
//
// Ports
//   clk, rst_i          : clock (rising edge) and async active-low reset
//   s_valid_i/s_ready_o : upstream handshake; push when both are high
//   s_data_i/s_key_i    : 64-bit block and 128-bit key
//   s_decrypt_i         : direction (1 = decrypt)
//   core_valid_o/en_o   : one-cycle request pulse to the core
//   core_data/key/decrypt_o : request payload, held from one issue to the next
//   core_result_i/valid_i/busy_i : core response and busy indication
//   m_valid_o/m_ready_i : downstream handshake
//   m_data_o/m_decrypt_o: result block and the direction it was issued with
//   err_o               : sticky timeout flag
//   blk_cnt_o           : completed (delivered) block count, wraps at 16 bits
// ----------------------------------------------------------------------------
module xtea_drv #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [63:0]  s_data_i,
  input  logic [127:0] s_key_i,
  input  logic         s_decrypt_i,
  output logic         core_valid_o,
  output logic         core_en_o,
  output logic [63:0]  core_data_o,
  output logic [127:0] core_key_o,
  output logic         core_decrypt_o,
  input  logic [63:0]  core_result_i,
  input  logic         core_valid_i,
  input  logic         core_busy_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [63:0]  m_data_o,
  output logic         m_decrypt_o,
  output logic         err_o,
  output logic [15:0]  blk_cnt_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 64 + 128 + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  // FSM and datapath state
  logic [1:0]       state_q,    state_d;
  logic [TMR_W-1:0] tmr_q,      tmr_d;
  logic [63:0]      cdata_q,    cdata_d;
  logic [127:0]     ckey_q,     ckey_d;
  logic             cdec_q,     cdec_d;
  logic [63:0]      mdata_q,    mdata_d;
  logic             mdec_q,     mdec_d;
  logic             err_q,      err_d;
  logic [15:0]      blk_cnt_q,  blk_cnt_d;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  // Ready looks only at the registered count, so a pop in the same cycle
  // never frees a slot for a push in that cycle.
  assign s_ready_o  = !fifo_full;
  assign push       = s_valid_i && !fifo_full;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty && !core_busy_i;
  assign head       = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: storage array has no reset; emptiness is defined by the reset
  // pointers and count, so clearing the entries would only cost flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_data_i, s_key_i, s_decrypt_i};
  end

  // --------------------------------------------------------------------------
  // Issue / wait / hold sequencer
  // --------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cdata_d   = cdata_q;
    ckey_d    = ckey_q;
    cdec_d    = cdec_q;
    mdata_d   = mdata_q;
    mdec_d    = mdec_q;
    err_d     = err_q;
    blk_cnt_d = blk_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          cdata_d = head[ENT_W-1 -: 64];
          ckey_d  = head[128:1];
          cdec_d  = head[0];
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        tmr_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (core_valid_i) begin
          mdata_d = core_result_i;
          mdec_d  = cdec_q;
          tmr_d   = '0;
          state_d = ST_HOLD;
        end else if (tmr_q == TMR_LAST) begin
          // TIMEOUT WAIT cycles have elapsed with no answer: drop the block.
          err_d   = 1'b1;
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
        end
      end

      ST_HOLD: begin
        if (m_ready_i) begin
          blk_cnt_d = blk_cnt_q + 16'd1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      cdata_q   <= '0;
      ckey_q    <= '0;
      cdec_q    <= 1'b0;
      mdata_q   <= '0;
      mdec_q    <= 1'b0;
      err_q     <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cdata_q   <= cdata_d;
      ckey_q    <= ckey_d;
      cdec_q    <= cdec_d;
      mdata_q   <= mdata_d;
      mdec_q    <= mdec_d;
      err_q     <= err_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The request pulse is decoded from ISSUE, which lasts exactly one cycle.
  assign core_valid_o   = (state_q == ST_ISSUE);
  assign core_en_o      = (state_q == ST_ISSUE);
  assign core_data_o    = cdata_q;
  assign core_key_o     = ckey_q;
  assign core_decrypt_o = cdec_q;
  assign m_valid_o      = (state_q == ST_HOLD);
  assign m_data_o       = mdata_q;
  assign m_decrypt_o    = mdec_q;
  assign err_o          = err_q;
  assign blk_cnt_o      = blk_cnt_q;

endmodule

// File: tb/tb_xtea_drv.sv
// ----------------------------------------------------------------------------
// tb_xtea_drv
//   Self-checking bench for xtea_drv. A behavioural XTEA core answers each
//   request after a programmable delay. Expected results are queued when a
//   block is pushed and are compared when the driver hands the block
//   downstream. A vector table covers the main data path, and hand-written
//   sequences cover backpressure, timeout, hold and mid-flight reset.
// ----------------------------------------------------------------------------
module tb_xtea_drv;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 255;
  localparam logic [31:0] DELTA   = 32'h9E3779B9;
  localparam logic [127:0] KEY0   = 128'h000102030405060708090A0B0C0D0E0F;

  logic         clk;
  logic         rst_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [63:0]  s_data_i;
  logic [127:0] s_key_i;
  logic         s_decrypt_i;
  logic         core_valid_o;
  logic         core_en_o;
  logic [63:0]  core_data_o;
  logic [127:0] core_key_o;
  logic         core_decrypt_o;
  logic [63:0]  core_result_i;
  logic         core_valid_i;
  logic         core_busy_i;
  logic         m_valid_o;
  logic         m_ready_i;
  logic [63:0]  m_data_o;
  logic         m_decrypt_o;
  logic         err_o;
  logic [15:0]  blk_cnt_o;

  xtea_drv #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .s_valid_i      (s_valid_i),
    .s_ready_o      (s_ready_o),
    .s_data_i       (s_data_i),
    .s_key_i        (s_key_i),
    .s_decrypt_i    (s_decrypt_i),
    .core_valid_o   (core_valid_o),
    .core_en_o      (core_en_o),
    .core_data_o    (core_data_o),
    .core_key_o     (core_key_o),
    .core_decrypt_o (core_decrypt_o),
    .core_result_i  (core_result_i),
    .core_valid_i   (core_valid_i),
    .core_busy_i    (core_busy_i),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_data_o       (m_data_o),
    .m_decrypt_o    (m_decrypt_o),
    .err_o          (err_o),
    .blk_cnt_o      (blk_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  typedef struct {
    logic [63:0] data;
    logic        dec;
  } exp_t;

  typedef struct {
    logic [63:0]  data;
    logic [127:0] key;
    logic         dec;
    logic [63:0]  exp;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec      = 0;
  int   n_err      = 0;
  int   issue_cnt  = 0;
  int   mvalid_cnt = 0;
  int   en_mis     = 0;
  int   core_delay = 32;
  bit   core_mute  = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference XTEA, 32 cycles; word 0 of the block and key is the MSB word.
  function automatic logic [63:0] xtea(input logic [63:0] d, input logic [127:0] k,
                                       input logic dec);
    logic [31:0] v0, v1, sum;
    logic [31:0] kw [4];
    for (int i = 0; i < 4; i++) kw[i] = k[127 - 32*i -: 32];
    v0 = d[63:32];
    v1 = d[31:0];
    if (!dec) begin
      sum = 32'h0;
      for (int r = 0; r < 32; r++) begin
        v0  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum[1:0]]));
        sum = sum + DELTA;
        v1  = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[sum[12:11]]));
      end
    end else begin
      sum = 32'hC6EF3720;
      for (int r = 0; r < 32; r++) begin
        v1  = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[sum[12:11]]));
        sum = sum - DELTA;
        v0  = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum[1:0]]));
      end
    end
    return {v0, v1};
  endfunction

  // Behavioural core: answers each request core_delay cycles later.
  initial begin
    logic [63:0] r;
    core_valid_i  = 1'b0;
    core_result_i = '0;
    forever begin
      @(negedge clk);
      if (core_valid_o && !core_mute) begin
        r = xtea(core_data_o, core_key_o, core_decrypt_o);
        repeat (core_delay) @(negedge clk);
        core_result_i = r;
        core_valid_i  = 1'b1;
        @(negedge clk);
        core_valid_i  = 1'b0;
      end
    end
  end

  // Activity counters.
  initial forever begin
    @(negedge clk);
    if (core_valid_o) issue_cnt++;
    if (m_valid_o) mvalid_cnt++;
    if (core_en_o !== core_valid_o) en_mis++;
  end

  // Scoreboard: compare each delivered block against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_i && m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got block %h with nothing expected", m_data_o);
        end else begin
          e = exp_q.pop_front();
          check("m_data", {64'h0, m_data_o}, {64'h0, e.data});
          check("m_decrypt", m_decrypt_o, e.dec);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge)
  // --------------------------------------------------------------------------
  task automatic push(input logic [63:0] d, input logic [127:0] k, input logic dec,
                      input bit expect_out);
    int n = 0;
    exp_t e;
    s_data_i    = d;
    s_key_i     = k;
    s_decrypt_i = dec;
    s_valid_i   = 1'b1;
    while (!s_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_o) begin
      check("push_timeout", s_ready_o, 1'b1);
      s_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid_i = 1'b0;
    if (expect_out) begin
      e.data = xtea(d, k, dec);
      e.dec  = dec;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!core_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("issue_seen", core_valid_o, 1'b1);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  vec_t vecs [6];
  int   exp_blk;

  initial begin
    logic [63:0] held;
    logic [15:0] bc;
    int          ic;
    int          mc;
    logic [63:0] pt;

    rst_i       = 1'b0;
    s_valid_i   = 1'b0;
    s_data_i    = '0;
    s_key_i     = '0;
    s_decrypt_i = 1'b0;
    core_busy_i = 1'b0;
    m_ready_i   = 1'b1;

    // Vector table; the decrypt row recovers a known plaintext.
    pt = 64'h0123456789ABCDEF;
    vecs[0] = '{64'h0123456789ABCDEF, KEY0, 1'b0, xtea(64'h0123456789ABCDEF, KEY0, 1'b0)};
    vecs[1] = '{xtea(pt, KEY0, 1'b0), KEY0, 1'b1, pt};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, {128{1'b1}}, 1'b0,
                xtea(64'hFFFFFFFFFFFFFFFF, {128{1'b1}}, 1'b0)};
    vecs[3] = '{64'hDEADBEEFCAFEF00D, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 1'b1,
                xtea(64'hDEADBEEFCAFEF00D, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 1'b1)};
    vecs[4] = '{64'h8000000000000001, 128'h80000000000000000000000000000001, 1'b0,
                xtea(64'h8000000000000001, 128'h80000000000000000000000000000001, 1'b0)};
    vecs[5] = '{64'h5555AAAA5555AAAA, 128'h0, 1'b1,
                xtea(64'h5555AAAA5555AAAA, 128'h0, 1'b1)};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready_o, 1'b1);
    check("rst_core_valid", core_valid_o, 1'b0);
    check("rst_core_en", core_en_o, 1'b0);
    check("rst_core_data", core_data_o, 64'h0);
    check("rst_core_key", core_key_o, 128'h0);
    check("rst_core_dec", core_decrypt_o, 1'b0);
    check("rst_m_valid", m_valid_o, 1'b0);
    check("rst_m_data", m_data_o, 64'h0);
    check("rst_m_dec", m_decrypt_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_blk_cnt", blk_cnt_o, 16'h0);
    rst_i = 1'b1;
    @(negedge clk);

    // ---- single encrypt, 32-cycle core, issue latency and pulse width ----
    ic = issue_cnt;
    push(64'h0, KEY0, 1'b0, 1'b1);
    check("lat_no_issue_yet", core_valid_o, 1'b0);
    @(negedge clk);
    check("lat_issue", core_valid_o, 1'b1);
    check("issue_data", core_data_o, 64'h0);
    check("issue_key", core_key_o, KEY0);
    check("issue_dec", core_decrypt_o, 1'b0);
    @(negedge clk);
    check("pulse_one_cycle", core_valid_o, 1'b0);
    drain();
    check("single_issue_cnt", issue_cnt - ic, 1);
    check("single_blk_cnt", blk_cnt_o, 16'd1);
    check("payload_held_key", core_key_o, KEY0);
    exp_blk = 1;

    // ---- table-driven vectors (includes encrypt/decrypt round trip) ----
    core_delay = 7;
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].data, vecs[i].key, vecs[i].dec, 1'b1);
      check("tbl_model_exp", {64'h0, exp_q[exp_q.size()-1].data}, {64'h0, vecs[i].exp});
      drain();
      exp_blk++;
      check("tbl_blk_cnt", blk_cnt_o, 16'(exp_blk));
      check("tbl_payload_held", core_data_o, vecs[i].data);
    end

    // ---- six back-to-back pushes against a busy core ----
    core_delay  = 5;
    core_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) push(64'h1000 + 64'(i), KEY0, i[0], 1'b1);
    check("full_after_4", s_ready_o, 1'b0);
    check("busy_no_issue", core_valid_o, 1'b0);
    fork
      begin
        push(64'h1004, KEY0, 1'b0, 1'b1);
        push(64'h1005, KEY0, 1'b1, 1'b1);
      end
      begin
        repeat (4) @(negedge clk);
        core_busy_i = 1'b0;
      end
    join
    drain();
    exp_blk += 6;
    check("burst_blk_cnt", blk_cnt_o, 16'(exp_blk));

    // ---- downstream stall in HOLD ----
    m_ready_i = 1'b0;
    push(64'hA5A5A5A5A5A5A5A5, KEY0, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!m_valid_o && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("hold_valid", m_valid_o, 1'b1);
    held = m_data_o;
    bc   = blk_cnt_o;
    push(64'h5A5A5A5A5A5A5A5A, KEY0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_data_stable", m_data_o, held);
      check("hold_no_issue", core_valid_o, 1'b0);
    end
    m_ready_i = 1'b1;
    @(negedge clk);
    check("hold_release_cnt", blk_cnt_o, 16'(bc + 16'd1));
    drain();
    exp_blk += 2;
    check("hold_blk_cnt", blk_cnt_o, 16'(exp_blk));

    // ---- core never answers: timeout after TIMEOUT WAIT cycles ----
    core_mute = 1'b1;
    push(64'h7777777777777777, KEY0, 1'b0, 1'b0);
    wait_issue();
    repeat (TIMEOUT) @(negedge clk);
    check("to_err_not_early", err_o, 1'b0);
    @(negedge clk);
    check("to_err_set", err_o, 1'b1);
    check("to_no_output", m_valid_o, 1'b0);
    // A stray response in IDLE must not produce output.
    core_result_i = 64'hBAD0BAD0BAD0BAD0;
    core_valid_i  = 1'b1;
    @(negedge clk);
    core_valid_i  = 1'b0;
    @(negedge clk);
    check("idle_resp_ignored", m_valid_o, 1'b0);
    core_mute = 1'b0;
    push(64'h2222222222222222, KEY0, 1'b0, 1'b1);
    drain();
    exp_blk++;
    check("to_next_blk_cnt", blk_cnt_o, 16'(exp_blk));
    check("to_err_sticky", err_o, 1'b1);

    // ---- reset while waiting with three blocks queued ----
    core_delay = 32;
    ic = issue_cnt;
    for (int i = 0; i < 4; i++) push(64'h3000 + 64'(i), KEY0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_one_issued", issue_cnt - ic, 1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_s_ready", s_ready_o, 1'b1);
    check("mid_rst_core_valid", core_valid_o, 1'b0);
    check("mid_rst_core_data", core_data_o, 64'h0);
    check("mid_rst_core_key", core_key_o, 128'h0);
    check("mid_rst_m_data", m_data_o, 64'h0);
    check("mid_rst_err", err_o, 1'b0);
    check("mid_rst_blk_cnt", blk_cnt_o, 16'h0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    ic = issue_cnt;
    mc = mvalid_cnt;
    repeat (60) @(negedge clk);
    check("post_rst_no_output", mvalid_cnt - mc, 0);
    check("post_rst_no_issue", issue_cnt - ic, 0);
    push(64'h4444444444444444, KEY0, 1'b0, 1'b1);
    drain();
    check("post_rst_blk_cnt", blk_cnt_o, 16'd1);

    check("en_tracks_valid", en_mis, 0);
    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
